// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM arbiter: address widths, read FSM states
// and the posted-write buffer entry layout.
package vram_pkg;

  localparam int VRAM_AW = 13;
  localparam int CPU_AW  = 14;

  typedef enum logic {
    S_IDLE,
    S_RD
  } rd_state_e;

  // lane selects the byte within the 16-bit word: 0 = [7:0], 1 = [15:8]
  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic               lane;
    logic [7:0]         data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Small synchronous FIFO holding posted CPU writes until a CPU slot lets them drain.
module wbuf_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  wbuf_entry_t din,
  output wbuf_entry_t dout,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);

  wbuf_entry_t     mem_q [DEPTH];
  logic [PW-1:0]   wrPtr_q, wrPtr_d;
  logic [PW-1:0]   rdPtr_q, rdPtr_d;
  logic [PW:0]     count_q, count_d;
  logic            doPush, doPop;

  assign full   = (count_q == (PW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign dout   = mem_q[rdPtr_q];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    // simultaneous push and pop leaves the occupancy unchanged
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (doPush) mem_q[wrPtr_q] <= din;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single-port video RAM between the gfx line fetcher (absolute priority)
// and the CPU, which posts writes through a buffer and reads only once it is drained.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int WBUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               gfx_active,
  input  logic [VRAM_AW-1:0] gfx_addr,
  output logic [15:0]        gfx_rddata,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [CPU_AW-1:0]  cpu_addr,
  input  logic [7:0]         cpu_wrdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rddata,
  output logic [VRAM_AW-1:0] ram_addr,
  output logic [15:0]        ram_wrdata,
  output logic [1:0]         ram_wren,
  input  logic [15:0]        ram_rddata,
  output logic               wbuf_empty
);

  rd_state_e   state_q, state_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdData_q, rdData_d;
  logic        rdLane_q, rdLane_d;

  logic        wrAccept, rdIssue, drain;
  logic        full, empty;
  wbuf_entry_t pushEntry, head;

  assign pushEntry = '{addr: cpu_addr[CPU_AW-1:1], lane: cpu_addr[0], data: cpu_wrdata};

  wbuf_fifo #(.DEPTH(WBUF_DEPTH)) uWbuf (
    .clk   (clk),
    .reset (reset),
    .push  (wrAccept),
    .pop   (drain),
    .din   (pushEntry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign gfx_rddata = ram_rddata;
  assign cpu_ack    = ack_q;
  assign cpu_rddata = rdData_q;
  assign wbuf_empty = empty;

  // A read only issues with an empty buffer, so a drain and a read never collide
  // and every earlier write reaches the RAM before the read samples it.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    rdData_d   = rdData_q;
    rdLane_d   = rdLane_q;
    wrAccept   = !reset && cpu_req && cpu_wr && !full && !ack_q;
    rdIssue    = !reset && (state_q == S_IDLE) && cpu_req && !cpu_wr && !ack_q
                 && empty && !gfx_active;
    drain      = !reset && !gfx_active && !empty;
    ram_addr   = gfx_addr;
    ram_wrdata = {head.data, head.data};
    ram_wren   = 2'b00;

    if (!gfx_active) begin
      if (drain) begin
        ram_addr = head.addr;
        ram_wren = head.lane ? 2'b10 : 2'b01;
      end else begin
        ram_addr = cpu_addr[CPU_AW-1:1];
      end
    end

    // S_RD completes even if gfx took the RAM this cycle: the data is from last cycle's address
    case (state_q)
      S_IDLE: begin
        if (rdIssue) begin
          state_d  = S_RD;
          rdLane_d = cpu_addr[0];
        end
      end
      S_RD: begin
        state_d  = S_IDLE;
        ack_d    = 1'b1;
        rdData_d = rdLane_q ? ram_rddata[15:8] : ram_rddata[7:0];
      end
      default: state_d = S_IDLE;
    endcase

    if (wrAccept) ack_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      rdData_q <= '0;
      rdLane_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdData_q <= rdData_d;
      rdLane_q <= rdLane_d;
    end
  end

endmodule
